memory_word_store: RTL and testbench

- Single-word, clocked read/write storage element with a one-bit mode control.
- In write mode, the input word is captured into the storage register. In read mode, the stored word is copied to a registered read port.
- The storage register is also exposed continuously as a debug/observation output.
- Used as a minimal RAM cell / register-file building block inside a larger datapath.

---
 rtl/memory_word_pkg.sv | 10 +
 rtl/memory_word_store.sv | 54 +++++
 tb/tb_memory_word_store.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/memory_word_pkg.sv
// Shared constants for the single-word store:
// default width and mode encodings.
package memory_word_pkg;

  localparam int WIDTH_DFLT = 2;

  localparam logic CNTRL_WRITE = 1'b0;
  localparam logic CNTRL_READ  = 1'b1;

endpackage

// File: rtl/memory_word_store.sv
// Single-word storage cell: WRITE captures inp into mem,
// READ copies the pre-edge mem into the registered read port.
module memory_word_store
  import memory_word_pkg::*;
#(
  parameter int WIDTH = WIDTH_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp,
  input  logic             cntrl,
  output logic [WIDTH-1:0] mem,
  output logic [WIDTH-1:0] read
);

  logic [WIDTH-1:0] mem_q;
  logic [WIDTH-1:0] mem_d;
  logic [WIDTH-1:0] read_q;
  logic [WIDTH-1:0] read_d;
  logic             is_read;

  // Anything other than a clean 1 on cntrl falls through to WRITE
  assign is_read = (cntrl == CNTRL_READ);

  always_comb begin
    mem_d  = mem_q;
    read_d = read_q;
    if (is_read) begin
      read_d = mem_q;
    end else begin
      mem_d = inp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_q <= '0;
    end else begin
      read_q <= read_d;
    end
  end

  assign mem  = mem_q;
  assign read = read_q;

endmodule

// File: tb/tb_memory_word_store.sv
// Scoreboard bench for memory_word_store: stimulus queues
// expected outputs, a monitor pops and compares them.
module tb_memory_word_store;
  import memory_word_pkg::*;

  localparam int W = 2;

  typedef struct {
    string      name;
    logic [W-1:0] m;
    logic [W-1:0] r;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] inp;
  logic         cntrl;
  logic [W-1:0] mem;
  logic [W-1:0] read;
  logic         smp;

  exp_t q[$];
  int   total;
  int   bad;

  memory_word_store #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .inp   (inp),
    .cntrl (cntrl),
    .mem   (mem),
    .read  (read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples 1 time unit after each edge or async probe
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge smp);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (mem !== e.m || read !== e.r) begin
          bad++;
          $display("FAIL %s: mem=%b read=%b, expected mem=%b read=%b",
                   e.name, mem, read, e.m, e.r);
        end
      end
    end
  end

  task automatic push(input string n, input logic [W-1:0] m,
                      input logic [W-1:0] r);
    exp_t e;
    e.name = n;
    e.m    = m;
    e.r    = r;
    q.push_back(e);
  endtask

  // Drive at negedge; optionally probe outputs before the next posedge
  task automatic step(input string n, input logic r,
                      input logic [W-1:0] i, input logic c,
                      input logic [W-1:0] em, input logic [W-1:0] er,
                      input bit chk, input logic [W-1:0] pm,
                      input logic [W-1:0] pr);
    @(negedge clk);
    #1;
    rst   = r;
    inp   = i;
    cntrl = c;
    if (chk) begin
      #1;
      push({n, "_async"}, pm, pr);
      smp = 1'b1;
      #2;
      smp = 1'b0;
    end
    push(n, em, er);
  endtask

  initial begin
    int wait_cyc;
    total = 0;
    bad   = 0;
    smp   = 1'b0;
    rst   = 1'b1;
    inp   = W'($urandom);
    cntrl = 1'($urandom);

    for (int k = 0; k < 3; k++) begin
      step("rst_hold", 1'b1, W'($urandom), 1'($urandom),
           2'b00, 2'b00, 1'b1, 2'b00, 2'b00);
    end

    step("rel_wr00", 1'b0, 2'b00, CNTRL_WRITE, 2'b00, 2'b00,
         1'b1, 2'b00, 2'b00);
    step("wr11", 1'b0, 2'b11, CNTRL_WRITE, 2'b11, 2'b00,
         1'b0, 2'b00, 2'b00);
    step("rd_11", 1'b0, 2'b00, CNTRL_READ, 2'b11, 2'b11,
         1'b0, 2'b00, 2'b00);
    step("wr01_keep_rd", 1'b0, 2'b01, CNTRL_WRITE, 2'b01, 2'b11,
         1'b0, 2'b00, 2'b00);
    step("rd_ign_inp", 1'b0, 2'b10, CNTRL_READ, 2'b01, 2'b01,
         1'b0, 2'b00, 2'b00);
    step("rd_hold1", 1'b0, 2'b10, CNTRL_READ, 2'b01, 2'b01,
         1'b0, 2'b00, 2'b00);
    step("rd_hold2", 1'b0, 2'b11, CNTRL_READ, 2'b01, 2'b01,
         1'b0, 2'b00, 2'b00);

    step("wr11_pre", 1'b0, 2'b11, CNTRL_WRITE, 2'b11, 2'b01,
         1'b0, 2'b00, 2'b00);
    step("rd11_pre", 1'b0, 2'b00, CNTRL_READ, 2'b11, 2'b11,
         1'b0, 2'b00, 2'b00);
    step("mid_rst", 1'b1, 2'b11, CNTRL_WRITE, 2'b00, 2'b00,
         1'b1, 2'b00, 2'b00);
    step("rel_rd00", 1'b0, 2'b10, CNTRL_READ, 2'b00, 2'b00,
         1'b1, 2'b00, 2'b00);

    step("b2b_01", 1'b0, 2'b01, CNTRL_WRITE, 2'b01, 2'b00,
         1'b0, 2'b00, 2'b00);
    step("b2b_10", 1'b0, 2'b10, CNTRL_WRITE, 2'b10, 2'b00,
         1'b0, 2'b00, 2'b00);
    step("b2b_11", 1'b0, 2'b11, CNTRL_WRITE, 2'b11, 2'b00,
         1'b0, 2'b00, 2'b00);
    step("rd_after_b2b", 1'b0, 2'b00, CNTRL_READ, 2'b11, 2'b11,
         1'b0, 2'b00, 2'b00);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
